slot_arbiter: RTL and testbench
===============================

# slot_arbiter

Round-robin arbiter with a bounded hold time. It shares one resource, such as a 3-bit up counter datapath, between up to 8 requesters. A 3-bit hold counter limits how long a requester may own the resource. The block sits between the requesters and the shared resource: it decides ownership and signals a forced release.

## Interface
- NREQ, 4: number of requesters, legal range 2..8.
- MAX_HOLD, 7: maximum grant length in cycles, legal range 1..7.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low.
- req  in  NREQ  level request, one bit per requester. Held high while the requester wants the resource.
- gnt  out  NREQ  one-hot grant, registered. All zero when no owner.
- gnt_id  out  3  index of current owner. Valid only while busy=1.
- busy  out  1  resource owned; equals |gnt.
- hold_cnt  out  3  cycles the current owner has held the grant, counting from 0.
- timeout  out  1  one-cycle pulse: grant was withdrawn because MAX_HOLD was reached.

## Operation
- Internal state: FSM (IDLE, GRANT), round-robin pointer ptr (0..NREQ-1), owner index, hold counter.
- Reset (rst=0, asynchronous): state IDLE, ptr=0, gnt=0, gnt_id=0, busy=0, hold_cnt=0, timeout=0.
  - Asserting reset mid-grant clears gnt immediately, without waiting for a clock edge.
- IDLE:
  - If req is nonzero, the winner is the first set bit found scanning ptr, ptr+1, … (mod NREQ).
  - At the edge: gnt[winner]=1, gnt_id=winner, hold_cnt=0, go to GRANT.
  - If req is zero, remain in IDLE with outputs zero.
- GRANT, evaluated at each edge in this priority order:
  1. req[owner]=0: gnt=0, ptr=(owner+1) mod NREQ, hold_cnt=0, go to IDLE, no timeout.
  2. hold_cnt==MAX_HOLD-1 with req[owner]=1: gnt=0, timeout=1 for one cycle, ptr=(owner+1) mod NREQ, hold_cnt=0, go to IDLE.
  3. Otherwise: hold_cnt+1, gnt unchanged.
- Requests from non-owners are ignored during GRANT; no preemption.
- The hold counter is 3 bits and never wraps. Its maximum value is MAX_HOLD-1 ≤ 6.
- A timed-out requester that keeps req high is re-queued at lowest priority. If it is the only requester it is re-granted after the gap cycle.
- Requester behaviour:
  - req may change in any cycle.
  - A req pulse that arrives and leaves while another requester owns the resource is lost. This is by design: requesters hold req until granted.
- NREQ=8: the pointer and gnt_id use the full 3 bits, and ptr wrap 7→0 is required.

## Timing
- Grant latency: req sampled high in IDLE at edge k produces gnt visible after edge k. Minimum one cycle from req rise to grant.
- Grant length: at most MAX_HOLD cycles (hold_cnt values 0..MAX_HOLD-1).
- Release latency: gnt falls at the first edge that samples req[owner]=0.
- Gap: exactly one cycle of gnt=0 between consecutive grants, even with requests pending. The arbitration decision is made in that IDLE cycle.
- timeout rises at the same edge gnt falls and is high for exactly one cycle.
- Simultaneous req drop and limit reached: release wins, timeout stays 0.
- All outputs are registered. There is no combinational path from req to gnt.

## Test plan
All scenarios use NREQ=4, MAX_HOLD=4 and a 10-unit clock period.
- Reset hold:
  - Stimulus: rst=0 for 3 cycles with req=4'b1111.
  - Required: gnt=0, busy=0, hold_cnt=0, timeout=0 throughout.
  - After rst rises, the first edge gives gnt=4'b0001, gnt_id=0.
- Voluntary release:
  - Stimulus: only req[1]=1 for 2 edges, then 0.
  - Required: gnt=4'b0010 for 2 cycles, hold_cnt 0→1; gnt=0 after the edge sampling req[1]=0; timeout stays 0.
- Round robin under saturation:
  - Stimulus: req=4'b1111 constant.
  - Required: gnt runs 0001×4, 0×1, 0010×4, 0×1, 0100×4, 0×1, 1000×4, 0×1, then 0001 again.
  - Timeout pulses once at each 4-cycle limit.
- Sole requester timeout:
  - Stimulus: req=4'b0100 constant.
  - Required: gnt=0100 for 4 cycles, timeout pulse, one gap cycle, then gnt=0100 again with hold_cnt restarting at 0.
- Coincident release and limit:
  - Stimulus: req[3] drops in the cycle where hold_cnt=3.
  - Required: gnt falls with timeout=0, and ptr advances to 0.
- Asynchronous reset mid-grant:
  - Stimulus: pull rst low between edges while gnt=4'b0100 and hold_cnt=2.
  - Required: gnt=0, hold_cnt=0 immediately.
  - After release with req=4'b0101, the next grant goes to req0.

Source files
------------

// File: rtl/slot_arbiter.sv
// slot_arbiter
//
// Round-robin arbiter with a bounded hold time. One shared resource is handed
// to one of NREQ requesters at a time. An owner keeps the grant while it holds
// its request high, for at most MAX_HOLD cycles; reaching the limit withdraws
// the grant and pulses timeout. Every grant is followed by exactly one idle
// cycle, in which the next winner is chosen starting from the requester after
// the previous owner.
//
// Handshake: req is a level request. A requester raises req[i] and keeps it
// high until it sees gnt[i]; it owns the resource for every cycle gnt[i] is
// high, and drops req[i] to give the resource back (sampled at the next edge).
// Requests that come and go while someone else owns the resource are not
// remembered.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   req        [NREQ-1:0] level requests
//   gnt        [NREQ-1:0] registered one-hot grant, zero when idle
//   gnt_id     [2:0] index of the current owner (meaningful while busy)
//   busy       resource currently owned (|gnt)
//   hold_cnt   [2:0] cycles the owner has held the grant, starting at 0
//   timeout    one-cycle pulse when a grant is withdrawn at the hold limit
//   dbg_state  FSM state: 0 = IDLE, 1 = GRANT

module slot_arbiter #(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [2:0]      gnt_id,
    output logic            busy,
    output logic [2:0]      hold_cnt,
    output logic            timeout,
    output logic            dbg_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [2:0] LAST_IDX  = 3'(NREQ - 1);
    localparam logic [2:0] HOLD_LAST = 3'(MAX_HOLD - 1);

    state_t          state, state_n;
    logic [2:0]      ptr, ptr_n;
    logic [NREQ-1:0] gnt_n;
    logic [2:0]      id_n;
    logic [2:0]      hold_n;
    logic            timeout_n;

    // Round-robin search results.
    logic [NREQ-1:0] rot;
    logic            found;
    logic [2:0]      win;
    logic [NREQ-1:0] win_onehot;
    int              sum;

    // The owner is the single set bit of gnt, so masking req with gnt gives
    // the owner's request without indexing by gnt_id.
    logic            owner_req;
    logic [2:0]      next_ptr;

    assign owner_req = |(req & gnt);
    assign next_ptr  = (gnt_id == LAST_IDX) ? 3'd0 : gnt_id + 3'd1;
    assign busy      = |gnt;
    assign dbg_state = state;

    // Rotate the requests so bit 0 is the requester at ptr, then take the
    // first set bit. Doubling the vector makes the rotation a plain shift.
    always_comb begin
        rot        = NREQ'({req, req} >> ptr);
        found      = 1'b0;
        win        = 3'd0;
        win_onehot = '0;
        sum        = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                sum   = int'(ptr) + i;
                if (sum >= NREQ) begin
                    sum = sum - NREQ;
                end
                win   = 3'(sum);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            win_onehot[j] = found && (3'(j) == win);
        end
    end

    // Next-state and next-output logic. All outputs are registered, so
    // there is no combinational path from req to gnt.
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        gnt_n     = gnt;
        id_n      = gnt_id;
        hold_n    = hold_cnt;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                gnt_n  = '0;
                hold_n = 3'd0;
                if (found) begin
                    gnt_n   = win_onehot;
                    id_n    = win;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                // A voluntary release takes priority over the hold limit,
                // so a coincident drop never reports a timeout.
                if (!owner_req) begin
                    gnt_n   = '0;
                    ptr_n   = next_ptr;
                    hold_n  = 3'd0;
                    state_n = IDLE;
                end else if (hold_cnt == HOLD_LAST) begin
                    gnt_n     = '0;
                    ptr_n     = next_ptr;
                    hold_n    = 3'd0;
                    timeout_n = 1'b1;
                    state_n   = IDLE;
                end else begin
                    hold_n = hold_cnt + 3'd1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                hold_n  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= 3'd0;
            gnt      <= '0;
            gnt_id   <= 3'd0;
            hold_cnt <= 3'd0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            gnt      <= gnt_n;
            gnt_id   <= id_n;
            hold_cnt <= hold_n;
            timeout  <= timeout_n;
        end
    end

endmodule

// File: tb/tb_slot_arbiter.sv
// Bench for slot_arbiter with NREQ=4, MAX_HOLD=4, 10-unit clock.
// The driver changes inputs on the falling edge and queues the output
// expected after the next rising edge; the monitor samples 2 units after
// every rising edge and compares against the head of the queue.

module tb_slot_arbiter;

    localparam int NREQ     = 4;
    localparam int MAX_HOLD = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] gnt;
    logic [2:0]      gnt_id;
    logic            busy;
    logic [2:0]      hold_cnt;
    logic            timeout;
    logic            dbg_state;

    always #5 clk = ~clk;

    slot_arbiter #(
        .NREQ     (NREQ),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .hold_cnt  (hold_cnt),
        .timeout   (timeout),
        .dbg_state (dbg_state)
    );

    // Packed observation: {gnt[3:0], gnt_id[2:0], busy, state, hold[2:0], timeout}
    logic [12:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic logic [12:0] mk(input logic [3:0] g, input logic [2:0] id,
                                       input logic [2:0] h, input logic t);
        return {g, id, |g, |g, h, t};
    endfunction

    function automatic logic [12:0] observe();
        return {gnt, gnt_id, busy, dbg_state, hold_cnt, timeout};
    endfunction

    task automatic check(input string nm, input logic [12:0] a_in, input logic [12:0] e_in);
        logic [12:0] a;
        logic [12:0] e;
        a = a_in;
        e = e_in;
        // gnt_id carries no meaning while nothing is granted.
        if (!e[5]) begin
            a[8:6] = 3'd0;
            e[8:6] = 3'd0;
        end
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL %s: got gnt=%b id=%0d busy=%b st=%b hold=%0d to=%b, expected gnt=%b id=%0d busy=%b st=%b hold=%0d to=%b",
                     nm, a[12:9], a[8:6], a[5], a[4], a[3:1], a[0],
                     e[12:9], e[8:6], e[5], e[4], e[3:1], e[0]);
        end
    endtask

    // Drive one cycle of inputs and queue the response expected after the
    // following rising edge.
    task automatic step(input logic rv, input logic [3:0] r,
                        input logic [12:0] e, input string nm);
        @(negedge clk);
        rst = rv;
        req = r;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor
    initial begin
        logic [12:0] e;
        string       nm;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, observe(), e);
            end
        end
    end

    // Driver
    initial begin
        // Reset hold: all requests up, outputs stay zero.
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 4'b1111, mk(4'b0000, 3'd0, 3'd0, 1'b0), $sformatf("reset_hold%0d", k));
        end

        // Round robin under saturation; the first step also releases reset,
        // so its edge gives the first grant to requester 0.
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                step(1'b1, 4'b1111, mk(4'(1 << k), 3'(k), 3'(j), 1'b0),
                     $sformatf("rr_own%0d_h%0d", k, j));
            end
            step(1'b1, 4'b1111, mk(4'b0000, 3'd0, 3'd0, 1'b1), $sformatf("rr_timeout%0d", k));
        end
        step(1'b1, 4'b1111, mk(4'b0001, 3'd0, 3'd0, 1'b0), "rr_wrap_to_0");

        // Back to idle, then a voluntary release by requester 1.
        step(1'b1, 4'b0000, mk(4'b0000, 3'd0, 3'd0, 1'b0), "drop_all_release");
        step(1'b1, 4'b0000, mk(4'b0000, 3'd0, 3'd0, 1'b0), "idle_no_req");
        step(1'b1, 4'b0010, mk(4'b0010, 3'd1, 3'd0, 1'b0), "vol_h0");
        step(1'b1, 4'b0010, mk(4'b0010, 3'd1, 3'd1, 1'b0), "vol_h1");
        step(1'b1, 4'b0000, mk(4'b0000, 3'd0, 3'd0, 1'b0), "vol_release");

        // Sole requester 2 times out and is re-granted after one gap cycle.
        step(1'b1, 4'b0100, mk(4'b0100, 3'd2, 3'd0, 1'b0), "sole_h0");
        step(1'b1, 4'b0100, mk(4'b0100, 3'd2, 3'd1, 1'b0), "sole_h1");
        step(1'b1, 4'b0100, mk(4'b0100, 3'd2, 3'd2, 1'b0), "sole_h2");
        step(1'b1, 4'b0100, mk(4'b0100, 3'd2, 3'd3, 1'b0), "sole_h3");
        step(1'b1, 4'b0100, mk(4'b0000, 3'd0, 3'd0, 1'b1), "sole_timeout");
        step(1'b1, 4'b0100, mk(4'b0100, 3'd2, 3'd0, 1'b0), "sole_regrant_h0");
        step(1'b1, 4'b0100, mk(4'b0100, 3'd2, 3'd1, 1'b0), "sole_regrant_h1");
        step(1'b1, 4'b0000, mk(4'b0000, 3'd0, 3'd0, 1'b0), "sole_release");

        // Requester 3 drops its request exactly when the limit is reached.
        step(1'b1, 4'b1000, mk(4'b1000, 3'd3, 3'd0, 1'b0), "coin_h0");
        step(1'b1, 4'b1000, mk(4'b1000, 3'd3, 3'd1, 1'b0), "coin_h1");
        step(1'b1, 4'b1000, mk(4'b1000, 3'd3, 3'd2, 1'b0), "coin_h2");
        step(1'b1, 4'b1000, mk(4'b1000, 3'd3, 3'd3, 1'b0), "coin_h3");
        step(1'b1, 4'b0000, mk(4'b0000, 3'd0, 3'd0, 1'b0), "coin_release_no_timeout");
        // Pointer must now be 0: with everyone requesting, requester 0 wins.
        step(1'b1, 4'b1111, mk(4'b0001, 3'd0, 3'd0, 1'b0), "coin_ptr_wrapped");
        step(1'b1, 4'b0000, mk(4'b0000, 3'd0, 3'd0, 1'b0), "coin_after_release");

        // Asynchronous reset while requester 2 holds with hold_cnt=2.
        step(1'b1, 4'b0100, mk(4'b0100, 3'd2, 3'd0, 1'b0), "arst_h0");
        step(1'b1, 4'b0100, mk(4'b0100, 3'd2, 3'd1, 1'b0), "arst_h1");
        step(1'b1, 4'b0100, mk(4'b0100, 3'd2, 3'd2, 1'b0), "arst_h2");
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("arst_immediate", observe(), mk(4'b0000, 3'd0, 3'd0, 1'b0));
        step(1'b0, 4'b0101, mk(4'b0000, 3'd0, 3'd0, 1'b0), "arst_held");
        step(1'b1, 4'b0101, mk(4'b0001, 3'd0, 3'd0, 1'b0), "arst_next_grant_req0");
        step(1'b1, 4'b0101, mk(4'b0001, 3'd0, 3'd1, 1'b0), "arst_next_h1");
        step(1'b1, 4'b0000, mk(4'b0000, 3'd0, 3'd0, 1'b0), "arst_final_release");

        // Let the monitor drain the queue, bounded.
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
            @(posedge clk);
            #3;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
